// File: rtl/huffman_decoder_pkg.sv
// Shared definitions for the Huffman decoder: table geometry, FSM state codes,
// the table-entry record and a low-bit mask helper.
package huffman_decoder_pkg;

    localparam int unsigned HUF_NUM_SYM = 8;
    localparam int unsigned HUF_MAX_LEN = 7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef struct packed {
        logic [3:0]             ch;
        logic [2:0]             len;
        logic [HUF_MAX_LEN-1:0] code;
    } tab_entry_t;

    function automatic logic [31:0] low_mask(input int unsigned n);
        low_mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/huffman_decoder_match.sv
// Parallel codeword compare of the pending prefix plus the incoming bit against
// every table entry; the lowest matching index wins.
module huff_match
    import huffman_decoder_pkg::*;
#(
    parameter int unsigned NUM_SYM = HUF_NUM_SYM,
    parameter int unsigned MAX_LEN = HUF_MAX_LEN,
    parameter int unsigned CNT_W   = 3,
    parameter int unsigned IDX_W   = 3
) (
    input  tab_entry_t         i_tab [NUM_SYM],
    input  logic [MAX_LEN-2:0] i_acc,
    input  logic               i_bit,
    input  logic [CNT_W-1:0]   i_cnt,
    output logic               o_hit,
    output logic [IDX_W-1:0]   o_idx
);

    logic [31:0]        w_need;
    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_word;

    assign w_need = 32'(i_cnt) + 32'd1;
    assign w_mask = MAX_LEN'(low_mask(w_need));
    assign w_word = {i_acc, i_bit} & w_mask;

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int unsigned i = 0; i < NUM_SYM; i++) begin
            if (!o_hit && (32'(i_tab[i].len) == w_need) &&
                ((MAX_LEN'(i_tab[i].code) & w_mask) == w_word)) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Huffman stream decoder: loads a code table, then decodes a serial bit stream
// one bit per strobe, emitting characters, error pulses and an end-of-stream pulse.
module huffman_decoder
    import huffman_decoder_pkg::*;
#(
    parameter int unsigned NUM_SYM = HUF_NUM_SYM,
    parameter int unsigned MAX_LEN = HUF_MAX_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_tab,
    input  logic [3:0]         tab_char,
    input  logic [2:0]         tab_len,
    input  logic [MAX_LEN-1:0] tab_code,
    input  logic               in_valid_bit,
    input  logic               in_bit,
    input  logic               in_last,
    output logic               out_valid,
    output logic [3:0]         out_char,
    output logic               out_err,
    output logic               out_done,
    output logic               busy
);

    localparam int unsigned IDX_W = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    tab_entry_t         r_tab [NUM_SYM];
    logic               r_tab_valid;
    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_load_idx;
    logic [MAX_LEN-2:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_valid;
    logic [3:0]         r_char_out;
    logic               r_err;
    logic               r_done;

    logic               w_tab_we;
    logic [IDX_W-1:0]   w_wr_idx;
    logic               w_take;
    logic               w_full;
    logic               w_hit;
    logic [IDX_W-1:0]   w_idx;

    assign w_tab_we = in_valid_tab && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
    assign w_wr_idx = (r_state == ST_IDLE) ? '0 : r_load_idx;
    // A loaded table also decodes from IDLE; a table strobe in IDLE takes priority.
    assign w_take   = in_valid_bit && r_tab_valid &&
                      ((r_state == ST_DECODE) || ((r_state == ST_IDLE) && !in_valid_tab));
    assign w_full   = (r_cnt == CNT_W'(MAX_LEN - 1));

    huff_match #(
        .NUM_SYM (NUM_SYM),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) u_match (
        .i_tab (r_tab),
        .i_acc (r_acc),
        .i_bit (in_bit),
        .i_cnt (r_cnt),
        .o_hit (w_hit),
        .o_idx (w_idx)
    );

    always_ff @(posedge clk) begin
        if (w_tab_we) begin
            r_tab[w_wr_idx] <= '{ch: tab_char, len: tab_len, code: tab_code};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tab_valid <= 1'b0;
            r_load_idx  <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_char_out  <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_char_out <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_tab) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        if (NUM_SYM == 1) begin
                            r_tab_valid <= 1'b1;
                            r_state     <= ST_DECODE;
                        end else begin
                            r_tab_valid <= 1'b0;
                            r_load_idx  <= IDX_W'(1);
                            r_state     <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (!in_valid_tab) begin
                        r_err      <= 1'b1;
                        r_load_idx <= '0;
                        r_state    <= ST_IDLE;
                    end else if (r_load_idx == IDX_W'(NUM_SYM - 1)) begin
                        r_tab_valid <= 1'b1;
                        r_load_idx  <= '0;
                        r_state     <= ST_DECODE;
                    end else begin
                        r_load_idx <= r_load_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // A truncated last codeword already raised out_done on entry.
                    r_done  <= !r_done;
                    r_state <= ST_IDLE;
                end
                default: ;
            endcase

            if (w_take) begin
                if (w_hit) begin
                    r_valid    <= 1'b1;
                    r_char_out <= r_tab[w_idx].ch;
                end else if (w_full || in_last) begin
                    r_err <= 1'b1;
                end
                if (w_hit || w_full || in_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= (MAX_LEN - 1)'({r_acc, in_bit});
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (in_last) begin
                    r_done  <= !w_hit && !w_full;
                    r_state <= ST_DONE;
                end else begin
                    r_state <= ST_DECODE;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_char  = r_char_out;
    assign out_err   = r_err;
    assign out_done  = r_done;
    assign busy      = (r_state == ST_LOAD) || (r_state == ST_DECODE);

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: directed scenarios plus random streams,
// every cycle compared against a prefix-code reference model.
module tb_huffman_decoder;

    localparam int unsigned NS = 8;
    localparam int unsigned ML = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid_tab = 1'b0;
    logic [3:0]     tab_char = '0;
    logic [2:0]     tab_len = '0;
    logic [ML-1:0]  tab_code = '0;
    logic           in_valid_bit = 1'b0;
    logic           in_bit = 1'b0;
    logic           in_last = 1'b0;
    logic           out_valid;
    logic [3:0]     out_char;
    logic           out_err;
    logic           out_done;
    logic           busy;

    always #5 clk = ~clk;

    huffman_decoder #(.NUM_SYM(NS), .MAX_LEN(ML)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_tab (in_valid_tab),
        .tab_char     (tab_char),
        .tab_len      (tab_len),
        .tab_code     (tab_code),
        .in_valid_bit (in_valid_bit),
        .in_bit       (in_bit),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_char     (out_char),
        .out_err      (out_err),
        .out_done     (out_done),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum {M_IDLE, M_LOAD, M_DECODE, M_DONE} mmode_t;
    mmode_t      m_mode = M_IDLE;
    int unsigned m_ch [NS];
    int unsigned m_len [NS];
    int unsigned m_code [NS];
    bit          m_tab_ok = 1'b0;
    bit          m_done_given = 1'b0;
    int unsigned m_n = 0, m_val = 0, m_nb = 0;
    logic        e_valid, e_err, e_done;
    logic [3:0]  e_char;

    int unsigned tb_ch [NS];
    int unsigned tb_len [NS];
    int unsigned tb_code [NS];

    int unsigned q_chars [$];
    int unsigned n_err = 0, n_done = 0, n_both = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_store(input int unsigned i);
        m_ch[i]   = tab_char;
        m_len[i]  = tab_len;
        m_code[i] = tab_code;
    endtask

    // Grow the pending prefix by one bit and apply the prefix-code rules.
    task automatic model_bit();
        int hit = -1;
        bit trunc;
        m_val = m_val * 2 + in_bit;
        m_nb++;
        for (int i = 0; i < NS; i++)
            if (hit < 0 && m_len[i] == m_nb && (m_code[i] % (1 << m_nb)) == m_val) hit = i;
        trunc = (hit < 0) && (m_nb < ML);
        if (hit >= 0) begin
            e_valid = 1'b1;
            e_char  = 4'(m_ch[hit]);
        end else if (m_nb == ML || in_last) begin
            e_err = 1'b1;
        end
        if (hit >= 0 || m_nb == ML || in_last) begin
            m_val = 0;
            m_nb  = 0;
        end
        if (in_last) begin
            m_mode       = M_DONE;
            m_done_given = trunc;
            e_done       = trunc;
        end else begin
            m_mode = M_DECODE;
        end
    endtask

    task automatic model_edge();
        e_valid = 1'b0; e_char = '0; e_err = 1'b0; e_done = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_val = 0; m_nb = 0; m_tab_ok = 1'b0; m_n = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (in_valid_tab) begin
                        m_tab_ok = 1'b0;
                        model_store(0);
                        m_n    = 1;
                        m_mode = M_LOAD;
                    end else if (in_valid_bit && m_tab_ok) begin
                        model_bit();
                    end
                end
                M_LOAD: begin
                    if (in_valid_tab) begin
                        model_store(m_n);
                        m_n++;
                        if (m_n == NS) begin
                            m_tab_ok = 1'b1;
                            m_mode   = M_DECODE;
                        end
                    end else begin
                        e_err  = 1'b1;
                        m_mode = M_IDLE;
                    end
                end
                M_DECODE: if (in_valid_bit) model_bit();
                M_DONE: begin
                    e_done = !m_done_given;
                    m_mode = M_IDLE;
                end
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", out_valid, e_valid);
        chk("out_char", out_char, e_char);
        chk("out_err", out_err, e_err);
        chk("out_done", out_done, e_done);
        chk("busy", busy, (m_mode == M_LOAD || m_mode == M_DECODE));
        if (out_valid === 1'b1) q_chars.push_back(out_char);
        if (out_err === 1'b1) n_err++;
        if (out_done === 1'b1) n_done++;
        if (out_err === 1'b1 && out_done === 1'b1) n_both++;
    endtask

    task automatic idle(input int n);
        in_valid_tab = 1'b0; in_valid_bit = 1'b0; in_last = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clear_rec();
        q_chars.delete();
        n_err = 0; n_done = 0; n_both = 0;
    endtask

    function automatic int unsigned pack_chars();
        int unsigned p = 0;
        foreach (q_chars[i]) p = p * 16 + q_chars[i];
        return p;
    endfunction

    task automatic set_t();
        for (int k = 0; k < NS; k++) begin
            tb_ch[k]   = 7 - k;
            tb_len[k]  = (k < 7) ? k + 1 : 7;
            tb_code[k] = (k < 7) ? (1 << (k + 1)) - 2 : 127;
        end
    endtask

    task automatic load_table(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid_tab = 1'b1;
            tab_char = 4'(tb_ch[i]);
            tab_len  = 3'(tb_len[i]);
            tab_code = 7'(tb_code[i]);
            cyc();
        end
        in_valid_tab = 1'b0;
    endtask

    task automatic send_bit(input bit b, input bit last);
        in_valid_bit = 1'b1; in_bit = b; in_last = last;
        if (m_mode == M_DECODE && $urandom_range(15, 0) == 0) begin
            in_valid_tab = 1'b1;
            tab_char = 4'($urandom);
            tab_len  = 3'($urandom_range(7, 1));
            tab_code = 7'($urandom);
        end
        cyc();
        in_valid_bit = 1'b0; in_last = 1'b0; in_valid_tab = 1'b0;
    endtask

    task automatic send_sym(input int k, input bit last);
        for (int j = int'(tb_len[k]) - 1; j >= 0; j--)
            send_bit(bit'((tb_code[k] >> j) & 1), last && j == 0);
    endtask

    initial begin
        rst = 1'b1;
        cyc();
        cyc();
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        idle(2);

        // Two-bit codeword "10" with last.
        set_t();
        load_table(NS);
        clear_rec();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        idle(3);
        chk("s037_nchars", q_chars.size(), 1);
        chk("s037_chars", pack_chars(), 32'h6);
        chk("s037_done", n_done, 1);

        // Mixed-length stream ending on the all-ones codeword.
        clear_rec();
        send_sym(0, 1'b0);
        send_sym(2, 1'b0);
        send_sym(7, 1'b1);
        idle(3);
        chk("s038_nchars", q_chars.size(), 3);
        chk("s038_chars", pack_chars(), 32'h750);
        chk("s038_done", n_done, 1);

        // Truncated last codeword.
        clear_rec();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        idle(3);
        chk("s040_nchars", q_chars.size(), 0);
        chk("s040_err_done", n_both, 1);

        // Sparse table: a full-length undecodable word, then decoding resumes.
        for (int i = 0; i < NS; i++) begin
            tb_ch[i] = i + 1; tb_len[i] = (i < 2) ? 2 : 7; tb_code[i] = (i == 1) ? 1 : 0;
        end
        load_table(NS);
        clear_rec();
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        idle(1);
        chk("s039_err", n_err, 1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        idle(3);
        chk("s039_chars", pack_chars(), 32'h2);

        // Aborted table load.
        set_t();
        clear_rec();
        load_table(5);
        cyc();
        chk("s041_busy", busy, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        idle(3);
        chk("s041_err", n_err, 1);
        chk("s041_nchars", q_chars.size(), 0);

        // Reset in the middle of a codeword, then reload.
        load_table(NS);
        clear_rec();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        load_table(NS);
        send_bit(1'b0, 1'b0);
        idle(2);
        chk("s042_chars", pack_chars(), 32'h7);
        chk("s042_err", n_err, 0);
        chk("s042_done", n_done, 0);

        // Random codeword stream from the reference table.
        for (int n = 0; n < 150; n++) begin
            send_sym($urandom_range(7, 0), n == 149);
            if ($urandom_range(3, 0) == 0) idle(1);
        end
        idle(3);

        // Random tables driven with random bits.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NS; i++) begin
                tb_ch[i] = $urandom_range(15, 0);
                tb_len[i] = $urandom_range(7, 1);
                tb_code[i] = $urandom_range(127, 0);
            end
            load_table(NS);
            for (int c = 0; c < 60; c++) begin
                if (c == 59 || $urandom_range(3, 0) != 0) send_bit(1'($urandom), c == 59);
                else idle(1);
            end
            idle(3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/huffman_decoder.md
HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 Parameter NUM_SYM, default 8: number of code-table entries (symbols).
REQ-002 Parameter MAX_LEN, default 7: maximum codeword length in bits.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port in_valid_tab  input  1: table-entry strobe; entries arrive on consecutive cycles, index 0 first.
REQ-006 Port tab_char  input  4: character id of the current entry.
REQ-007 Port tab_len  input  3: codeword length of the entry, 1..MAX_LEN.
REQ-008 Port tab_code  input  MAX_LEN: codeword right-aligned; bit tab_len-1 is transmitted first.
REQ-009 Port in_valid_bit  input  1: stream-bit strobe.
REQ-010 Port in_bit  input  1: stream bit.
REQ-011 Port in_last  input  1: qualifies in_valid_bit; the bit is the final bit of the stream.
REQ-012 Port out_valid  output  1: one-cycle pulse; out_char holds a decoded character.
REQ-013 Port out_char  output  4: decoded character id; 0 when out_valid is low.
REQ-014 Port out_err  output  1: one-cycle pulse on an undecodable codeword.
REQ-015 Port out_done  output  1: one-cycle pulse, stream finished.
REQ-016 Port busy  output  1: high in LOAD and DECODE states.

Function
REQ-017 FSM states: IDLE, LOAD, DECODE, DONE; one-hot or binary encoding is free.
REQ-018 IDLE: in_valid_tab high stores entry 0 and moves to LOAD; in_valid_bit is ignored.
REQ-019 LOAD: each in_valid_tab cycle stores the next entry; after entry NUM_SYM-1 is stored, the next state is DECODE.
REQ-020 LOAD: if in_valid_tab drops before the table is complete, the partial load is discarded, out_err pulses for one cycle, and the next state is IDLE.
REQ-021 DECODE: each in_valid_bit cycle appends in_bit to the accumulator (acc) and increments the bit count (cnt, 0..MAX_LEN); cycles without in_valid_bit hold acc and cnt.
REQ-022 Match rule: entry i matches when tab_len[i] == cnt+1 and tab_code[i][cnt:0] equals {acc, in_bit}.
REQ-023 If several entries match, the lowest index wins.
REQ-024 On a match: out_valid=1 and out_char=tab_char[i] in the cycle after the completing bit (latency 1); acc and cnt clear.
REQ-025 No match and cnt+1 == MAX_LEN: out_err pulses in the next cycle; acc and cnt clear; decoding continues.
REQ-026 A bit with in_last high: the match/err rules apply first. If no match and cnt+1 < MAX_LEN, out_err pulses. Next state is DONE in every case.
REQ-027 DONE: out_done pulses for exactly one cycle; the next state is IDLE; the table is retained.
REQ-028 IDLE with in_valid_bit high while a valid table is held: the bit is treated as in DECODE. Loading a new table always overwrites the old one.
REQ-029 out_valid, out_err and out_done are registered and never asserted in the same cycle, except out_err together with out_done on a truncated last codeword.
REQ-030 in_valid_tab and in_valid_bit asserted together in DECODE: the table strobe is ignored and the bit is processed.

Reset
REQ-031 rst high at a clock edge: state=IDLE, acc=0, cnt=0, table-valid flag=0, and every output=0 in the following cycle.
REQ-032 Reset mid-LOAD or mid-DECODE aborts the operation and produces no out_done or out_err pulse.
REQ-033 Table storage contents need not be reset; the table-valid flag gates all use of it.

Structure
REQ-034 A shared package holds NUM_SYM, MAX_LEN, the state enumeration and the table-entry record (char, len, code).
REQ-035 One sub-module, huff_match: combinational parallel compare of {acc, in_bit}/cnt against all entries, with a lowest-index priority encoder; outputs hit and index.
REQ-036 Target implementation size is 120-400 lines of RTL.

Verification
Reference table T: char k=7-k for k=0..7; codes 0, 10, 110, 1110, 11110, 111110, 1111110, 1111111.
REQ-037 Bench: load T, then bits 1,0 with in_last on 0 -> out_valid with out_char=6 one cycle after the second bit, then out_done one cycle later.
REQ-038 Bench: load T, then stream 0 1 1 0 1 1 1 1 1 1 1 -> out_char sequence 7, 5, 0, followed by out_done.
REQ-039 Bench: table with codes 00 and 01 only, all other entries len 7 code 0000000, stream 1111111 -> out_err one cycle after the 7th bit, then decoding continues.
REQ-040 Bench: load T, bits 1,1 with in_last -> out_err and out_done in the same cycle; no out_valid.
REQ-041 Bench: in_valid_tab drops after 5 entries -> out_err pulse, busy=0, and subsequent bits produce no output.
REQ-042 Bench: rst asserted after 3 bits of a 4-bit codeword -> all outputs 0 the next cycle; a reload of T followed by bit 0 yields out_char=7.
